// File: rtl/dl_timer_sched.sv
// Shared-timer scheduler: round-robin arbitration of NUM_REQ timeout requests
// onto a single up-counter, with a one-cycle done pulse on the owner's lane.
module dl_timer_sched #(
    parameter int NUM_REQ  = 4,
    parameter int CNT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*CNT_BITS-1:0]  req_len,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         abort,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic [CNT_BITS-1:0]          count
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_BITS-1:0] len_q;

    logic               grant_valid;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   next_ptr;
    logic [CNT_BITS-1:0] win_len;
    logic [PTR_W:0]     idx_w;
    logic               accept;

    // Search from rr_ptr upward with modulo wrap; the first pending lane wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        winner      = '0;
        idx_w       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx_w >= (PTR_W+1)'(NUM_REQ))
                idx_w = idx_w - (PTR_W+1)'(NUM_REQ);
            if (!grant_valid && req_valid[idx_w[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                winner      = idx_w[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_len = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PTR_W'(k) == winner)
                win_len = req_len[k*CNT_BITS +: CNT_BITS];
        end
    end

    always_comb begin
        if (winner == PTR_W'(NUM_REQ - 1))
            next_ptr = '0;
        else
            next_ptr = winner + PTR_W'(1);
    end

    assign accept = (state == IDLE) && grant_valid;

    always_comb begin
        req_ready = '0;
        if (rst_n && accept)
            req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset here is synchronous and covers every register.
        if (!rst_n) begin
            state  <= IDLE;
            done   <= '0;
            busy   <= 1'b0;
            owner  <= '0;
            count  <= '0;
            rr_ptr <= '0;
            len_q  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        len_q  <= win_len;
                        owner  <= winner;
                        count  <= '0;
                        rr_ptr <= next_ptr;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == len_q) begin
                        // Counter parks at L so it never wraps, even for L = 2^CNT_BITS-1.
                        done[owner] <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count + CNT_BITS'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dl_timer_sched.sv
// Directed bench for dl_timer_sched: table of single-job vectors plus
// hand-written round-robin, late-arrival, abort and mid-run reset sequences.
module tb_dl_timer_sched;

    localparam int N  = 4;
    localparam int CB = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*CB-1:0] req_len = '0;
    logic            abort = 1'b0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    done;
    logic            busy;
    logic [1:0]      owner;
    logic [CB-1:0]   count;

    int checks = 0;
    int errors = 0;

    int grant_q[$];
    int grant_cyc[$];
    int done_q[$];

    typedef struct {
        int         lane;
        int         len;
        int         exp_lat;
        logic [3:0] exp_done;
    } vec_t;

    vec_t vecs[5];

    dl_timer_sched #(.NUM_REQ(N), .CNT_BITS(CB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .abort     (abort),
        .done      (done),
        .busy      (busy),
        .owner     (owner),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read later in the same cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lane_of(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        abort     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int  lat;
        int  maxc;
        int  t;
        bit  seq_ok;
        bit  got;
        logic [3:0] dl;
        req_len[v.lane*CB +: CB] = CB'(v.len);
        req_valid[v.lane] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[v.lane] && t < 20) begin
            step();
            #1;
            t++;
        end
        check("vec grant", req_ready, 32'(1 << v.lane));
        step();
        req_valid[v.lane] = 1'b0;
        lat    = 1;
        maxc   = 0;
        seq_ok = 1'b1;
        got    = 1'b0;
        dl     = '0;
        while (lat <= v.len + 10) begin
            if (done != 0) begin
                got = 1'b1;
                dl  = done;
                break;
            end
            if (int'(count) != lat - 1 || !busy) seq_ok = 1'b0;
            if (int'(count) > maxc) maxc = int'(count);
            step();
            lat++;
        end
        check("vec latency", got ? lat : -1, v.exp_lat);
        check("vec done lane", dl, v.exp_done);
        check("vec owner", owner, v.lane);
        check("vec count seq", seq_ok, 1);
        check("vec count max", maxc, v.len);
        check("vec busy in done", busy, 1);
        step();
        check("vec busy after", busy, 0);
        check("vec done after", done, 0);
    endtask

    task automatic collect(input int n, input bit hold, input int budget);
        int  gi;
        bit  granted;
        grant_q.delete();
        grant_cyc.delete();
        done_q.delete();
        for (int c = 0; c < budget && done_q.size() < n; c++) begin
            #1;
            granted = 1'b0;
            if (done != 0) done_q.push_back(lane_of(done));
            if (req_ready != 0) begin
                gi      = lane_of(req_ready);
                granted = 1'b1;
                grant_q.push_back(gi);
                grant_cyc.push_back(c);
            end
            step();
            if (granted && !hold) req_valid[gi] = 1'b0;
        end
    endtask

    initial begin
        int  t;
        bit  done_seen;

        vecs[0] = '{lane: 1, len: 3,   exp_lat: 5,   exp_done: 4'b0010};
        vecs[1] = '{lane: 0, len: 0,   exp_lat: 2,   exp_done: 4'b0001};
        vecs[2] = '{lane: 2, len: 7,   exp_lat: 9,   exp_done: 4'b0100};
        vecs[3] = '{lane: 3, len: 1,   exp_lat: 3,   exp_done: 4'b1000};
        vecs[4] = '{lane: 1, len: 255, exp_lat: 257, exp_done: 4'b0010};

        do_reset();
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset owner", owner, 0);
        check("reset count", count, 0);
        check("reset ready", req_ready, 0);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i]);

        // Round-robin among lanes 0, 2, 3 held continuously valid with L=1.
        do_reset();
        req_len = {8'd1, 8'd1, 8'd1, 8'd1};
        req_valid = 4'b1101;
        collect(6, 1'b1, 60);
        req_valid = '0;
        check("rr n grants", grant_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("rr grant order", qget(grant_q, i), (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 3);
            check("rr done order", qget(done_q, i), (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 3);
        end
        for (int i = 0; i < 5; i++)
            check("rr accept gap", qget(grant_cyc, i + 1) - qget(grant_cyc, i), 4);

        // Late arrival: lane 3 then lane 1 assert while lane 0 runs.
        do_reset();
        req_len = {8'd2, 8'd2, 8'd2, 8'd5};
        req_valid = 4'b0001;
        #1;
        check("late first ready", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        step();
        req_valid[3] = 1'b1;
        step();
        req_valid[1] = 1'b1;
        #1;
        check("late ready in run", req_ready, 0);
        collect(3, 1'b0, 60);
        check("late n grants", grant_q.size(), 2);
        check("late grant 0", qget(grant_q, 0), 1);
        check("late grant 1", qget(grant_q, 1), 3);
        check("late done 0", qget(done_q, 0), 0);
        check("late done 1", qget(done_q, 1), 1);
        check("late done 2", qget(done_q, 2), 3);

        // Abort lane 2 at count 4; pending lane 3 follows.
        do_reset();
        req_len = {8'd2, 8'd10, 8'd0, 8'd0};
        req_valid = 4'b1100;
        #1;
        check("abort first ready", req_ready, 4'b0100);
        step();
        req_valid[2] = 1'b0;
        done_seen = 1'b0;
        t = 0;
        while (count != 8'd4 && t < 20) begin
            if (done != 0) done_seen = 1'b1;
            step();
            t++;
        end
        check("abort at count", count, 4);
        check("abort busy before", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort count", count, 0);
        check("abort no done in run", done_seen, 0);
        check("abort next ready", req_ready, 4'b1000);
        step();
        req_valid[3] = 1'b0;
        check("abort next owner", owner, 3);
        check("abort next busy", busy, 1);
        t = 0;
        while (done == 0 && t < 20) begin
            step();
            t++;
        end
        check("abort next done", done, 4'b1000);

        // Reset for one cycle at count 5 while lane 0 runs; rr_ptr would otherwise favour lane 1.
        step();
        step();
        req_len = {8'd0, 8'd0, 8'd3, 8'd10};
        req_valid = 4'b0001;
        #1;
        check("rst first ready", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        t = 0;
        while (count != 8'd5 && t < 20) begin
            step();
            t++;
        end
        check("rst at count", count, 5);
        rst_n = 1'b0;
        req_valid = 4'b0011;
        #1;
        check("rst ready forced low", req_ready, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst owner", owner, 0);
        check("rst count", count, 0);
        check("rst winner lane 0", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        check("rst new owner", owner, 0);
        check("rst new busy", busy, 1);
        done_seen = 1'b0;
        t = 0;
        while (done == 0 && t < 20) begin
            step();
            t++;
        end
        check("rst lane 0 done", done, 4'b0001);
        req_valid = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl_timer_sched.md
# dl_timer_sched

Shared-timer scheduler that multiplexes a single internal up-counter between `NUM_REQ` requesters, each asking for a timeout of its own length. Requests are arbitrated round-robin and accepted with a valid/ready handshake. The shared counter is run to the winner's length, and a one-cycle `done` pulse is returned on the winner's lane. The block sits between control FSMs that need wait states (e.g. memory/peripheral settle delays) and the counter library, so only one counter instance is needed per cluster.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `CNT_BITS`, default 8: width of each length field and of the internal counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request; must be held until accepted.
- `req_len` in NUM_REQ*CNT_BITS: per-requester length L; lane i occupies bits [i*CNT_BITS +: CNT_BITS]; must be stable while `req_valid[i]` is high.
- `req_ready` out NUM_REQ: one-hot grant; a transfer occurs on lane i when `req_valid[i] & req_ready[i]` at a rising edge.
- `abort` in 1: cancels the running timeout.
- `done` out NUM_REQ: registered one-hot, one-cycle expiry pulse on the owner's lane.
- `busy` out 1: registered; high in RUN and DONE.
- `owner` out $clog2(NUM_REQ): registered index of the accepted requester.
- `count` out CNT_BITS: registered current counter value (debug/observability).

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `req_ready` is driven combinationally as one-hot on the winner: the first set `req_valid` bit searching from `rr_ptr` upward, with modulo wrap.
  - `req_ready` is all-zero if no request is pending, and all-zero in RUN and DONE.
  - On a transfer: latch `req_len[winner]` into `len_q`, set `owner` to the winner, clear `count` to 0, set `rr_ptr` to (winner+1) mod NUM_REQ, and go to RUN.
- **RUN**
  - If `abort` is high: go to IDLE and clear `count`; no `done` pulse; `rr_ptr` is unchanged from its value at accept.
  - Else if `count == len_q`: go to DONE.
  - Else: `count` increments by 1.
  - `count` never wraps: the maximum L is 2^CNT_BITS−1 and `count` stops at L.
- **DONE**
  - `done[owner]` = 1 for exactly this cycle; go to IDLE unconditionally.
  - `abort` is ignored in DONE and in IDLE.
- `owner` holds its value through IDLE until the next accept.
- Reset values: state = IDLE, `done` = 0, `busy` = 0, `owner` = 0, `count` = 0, `rr_ptr` = 0, `len_q` = 0. `req_ready` is forced to 0 while `rst_n` is low.
- Reset asserted mid-RUN or mid-DONE: return to IDLE at that edge with all of the reset values above, and no `done` pulse. The interrupted requester's request is lost; the requester must re-request.
- Requesters that are not granted keep `req_valid` asserted. They are never dropped, only delayed.

## Timing
- Accept edge at cycle k, with length L:
  - RUN occupies cycles k+1 … k+L+1 (L+1 cycles), with `count` = 0…L.
  - DONE, and the `done` pulse, occur in cycle k+L+2.
  - IDLE is entered in cycle k+L+3, which is the earliest next accept.
- Job period is L+3 cycles.
- L = 0 gives one RUN cycle, with `done` in cycle k+2.
- `busy` rises in cycle k+1 and falls in the first IDLE cycle (k+L+3, or the cycle after abort is sampled).
- `abort` sampled at the edge ending RUN cycle j gives IDLE in cycle j+1, with `busy` low in j+1.
- Round-robin fairness: with all lanes continuously valid, grants rotate 0,1,…,NUM_REQ−1,0…. Any waiting requester is granted within NUM_REQ accepts.

## Test plan
- **Single request:** lane 1 requests with L=3, accepted at cycle 0 → `busy` high in cycles 1–5; `count` = 0,1,2,3 in cycles 1–4; `done` = 0b0010 in cycle 5 only; `owner` = 1; next `req_ready` possible in cycle 6.
- **L=0 and max:** L=0 → `done` in cycle 2. L=255 with CNT_BITS=8 → `done` in cycle 257; `count` never exceeds 255 and never wraps to 0 mid-RUN.
- **Round-robin:** lanes 0, 2 and 3 hold `req_valid` with L=1 → grant order 0,2,3,0,2,3. Each `done` is on the matching lane; accepts are 4 cycles apart.
- **Late arrival:** lane 0 is running when lane 3 and then lane 1 assert → next grant is 1 (`rr_ptr` = 1), then 3. Neither request is lost.
- **Abort:** lane 2 with L=10, `abort` pulsed in RUN at `count` = 4 → IDLE the next cycle; no `done` on any lane; `busy` low; a pending lane 3 is then granted.
- **Reset mid-operation:** `rst_n` low for 1 cycle at `count` = 5 → all outputs at their reset values; no `done`; `rr_ptr` = 0, so lane 0 wins a subsequent simultaneous request from lanes 0 and 1.
